// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and range check for the data-RAM arbiter.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    localparam int DMEM_BYTES_PER_WORD = 8;
    localparam logic REQ_PL = 1'b0;
    localparam logic REQ_LD = 1'b1;
    function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] mem_bytes);
        return addr <= mem_bytes - 64'(DMEM_BYTES_PER_WORD);
    endfunction
endpackage

// File: rtl/dmem_grant_pick.sv
// dmem_grant_pick: 2-way requester picker (fixed pipeline priority, or round robin
// under DMEM_ROUND_ROBIN_EN) plus the registered owner of the current/last grant.
module dmem_grant_pick
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pl_req,
    input  logic ld_req,
    input  logic take,
    output logic pick,
    output logic grant_ld
);
`ifdef DMEM_ROUND_ROBIN_EN
    logic last;
    // Starts at the loader so the pipeline takes the first contested grant.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last <= REQ_LD;
        else if (take) last <= pick;
    assign pick = (pl_req && ld_req) ? ((last == REQ_LD) ? REQ_PL : REQ_LD)
                                     : (ld_req ? REQ_LD : REQ_PL);
`else
    assign pick = pl_req ? REQ_PL : (ld_req ? REQ_LD : REQ_PL);
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) grant_ld <= 1'b0;
        else if (take) grant_ld <= pick;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the byte-wide data RAM between pipeline and loader, one 64-bit
// access per grant as 8 byte cycles. Optional round robin via DMEM_ROUND_ROBIN_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 2048,
    parameter int AW        = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pl_req,
    input  logic          pl_we,
    input  logic [63:0]   pl_addr,
    input  logic [63:0]   pl_wdata,
    output logic          pl_ack,
    output logic [63:0]   pl_rdata,
    output logic          pl_err,
    output logic          pl_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [63:0]   ld_addr,
    input  logic [63:0]   ld_wdata,
    output logic          ld_ack,
    output logic [63:0]   ld_rdata,
    output logic          ld_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          grant_ld
);
    state_t state, state_nx;
    logic [2:0] cnt;
    logic we, err, pick, take, in_range;
    logic [AW-1:0] addr;
    logic [63:0] wdata, sel_addr, rd_word, pl_rdata_q, ld_rdata_q;
    logic [55:0] rdbuf;

    assign take     = (state == IDLE) && (pl_req || ld_req);
    assign sel_addr = pick ? ld_addr : pl_addr;
    assign in_range = addr_ok(sel_addr, 64'(MEM_BYTES));

    dmem_grant_pick u_pick (
        .clk(clk), .rst_n(rst_n), .pl_req(pl_req), .ld_req(ld_req),
        .take(take), .pick(pick), .grant_ld(grant_ld)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx  = (state == IDLE) ? (take ? (in_range ? XFER : RESP) : IDLE)
                  : (state == XFER) ? ((cnt == 3'd7) ? RESP : XFER) : IDLE;
        busy      = state != IDLE;
        mem_we    = (state == XFER) && we;
        mem_addr  = (state == XFER) ? addr + AW'(cnt) : '0;
        mem_wdata = mem_we ? wdata[7:0] : '0;
        pl_ack    = (state == RESP) && !grant_ld;
        ld_ack    = (state == RESP) && grant_ld;
        pl_err    = pl_ack && err;
        ld_err    = ld_ack && err;
        pl_stall  = pl_req && !pl_ack;
        // Byte 7 is still on mem_rdata during RESP, so it joins the word combinationally.
        rd_word   = {mem_rdata, rdbuf};
        pl_rdata  = (pl_ack && !we && !err) ? rd_word : pl_rdata_q;
        ld_rdata  = (ld_ack && !we && !err) ? rd_word : ld_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt        <= '0;
            we         <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            rdbuf      <= '0;
            pl_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (take) begin
                cnt   <= '0;
                we    <= pick ? ld_we : pl_we;
                wdata <= pick ? ld_wdata : pl_wdata;
                addr  <= sel_addr[AW-1:0];
                err   <= !in_range;
            end
            // Write bytes shift out LSB first; read bytes shift in from the top.
            if (state == XFER) begin
                cnt   <= cnt + 3'd1;
                wdata <= wdata >> 8;
                if (cnt != 3'd0) rdbuf <= {mem_rdata, rdbuf[55:8]};
            end
            pl_rdata_q <= pl_rdata;
            ld_rdata_q <= ld_rdata;
        end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a byte RAM model.
module tb_dmem_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic pl_req = 1'b0, pl_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
    logic [63:0] pl_addr = '0, pl_wdata = '0, ld_addr = '0, ld_wdata = '0;
    logic pl_ack, pl_err, pl_stall, ld_ack, ld_err, mem_we, busy, grant_ld;
    logic [63:0] pl_rdata, ld_rdata;
    logic [10:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] ram [2048];
    int n_cmp = 0, n_fail = 0;
    logic [10:0] wa [8];
    logic [7:0] wd [8];
    int wc [8];
    logic ack_err;
    logic [63:0] ack_rd;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .pl_req(pl_req), .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata),
        .pl_ack(pl_ack), .pl_rdata(pl_rdata), .pl_err(pl_err), .pl_stall(pl_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_ld(grant_ld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [63:0] word_at(input int a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ram[11'(a + i)];
        return w;
    endfunction

    // One request on one port; request fields are scrambled mid-transfer to prove latching.
    task automatic txn(input logic ld, input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       output int lat, output int nwe, output int nstall);
        @(posedge clk); #1;
        if (ld) begin ld_req = 1; ld_we = we; ld_addr = addr; ld_wdata = wdata; end
        else begin pl_req = 1; pl_we = we; pl_addr = addr; pl_wdata = wdata; end
        lat = -1; nwe = 0; nstall = 0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_we && nwe < 8) begin wa[nwe] = mem_addr; wd[nwe] = mem_wdata; wc[nwe] = c; end
            if (mem_we) nwe++;
            if (pl_stall) nstall++;
            if (ld ? ld_ack : pl_ack) begin lat = c; ack_err = ld ? ld_err : pl_err; ack_rd = ld ? ld_rdata : pl_rdata; end
            if (c == 2) begin
                if (ld) begin ld_we = ~we; ld_addr = addr + 16; ld_wdata = ~wdata; end
                else begin pl_we = ~we; pl_addr = addr + 16; pl_wdata = ~wdata; end
            end
        end
        @(posedge clk); #1;
        pl_req = 0; ld_req = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({pl_ack, ld_ack, pl_err, ld_err, mem_we, busy, grant_ld} !== 7'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000000", {pl_ack, ld_ack, pl_err, ld_err, mem_we, busy, grant_ld}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 19'h0) begin n_fail++; $display("FAIL reset_mem got %h want 0", {mem_addr, mem_wdata}); end
        n_cmp++; if ({pl_rdata, ld_rdata} !== 128'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", {pl_rdata, ld_rdata}); end
        rst_n = 1;
    endtask

    task automatic test_pl_write;
        int lat, nwe, ns;
        logic [63:0] d = 64'h1122334455667788;
        txn(0, 1, 64'h100, d, lat, nwe, ns);
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL wr_latency got %0d want 9", lat); end
        n_cmp++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", ack_err); end
        n_cmp++; if (nwe !== 8) begin n_fail++; $display("FAIL wr_strobes got %0d want 8", nwe); end
        for (int i = 0; i < 8 && i < nwe; i++) begin
            n_cmp++; if (wa[i] !== 11'(256 + i) || wd[i] !== d[8*i +: 8] || wc[i] !== i + 1) begin n_fail++;
                $display("FAIL wr_byte%0d got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d", i, wa[i], wd[i], wc[i], 11'(256 + i), d[8*i +: 8], i + 1); end
        end
        n_cmp++; if (word_at(256) !== d) begin n_fail++; $display("FAIL wr_ram got %h want %h", word_at(256), d); end
    endtask

    task automatic test_pl_read;
        int lat, nwe, ns;
        txn(0, 0, 64'h100, 64'h0, lat, nwe, ns);
        n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL rd_latency got %0d want 9", lat); end
        n_cmp++; if (ack_rd !== 64'h1122334455667788 || ack_err !== 1'b0) begin n_fail++; $display("FAIL rd_data got %h/%b want 1122334455667788/0", ack_rd, ack_err); end
        n_cmp++; if (ns !== 9) begin n_fail++; $display("FAIL rd_stall got %0d want 9", ns); end
        n_cmp++; if (nwe !== 0) begin n_fail++; $display("FAIL rd_no_we got %0d want 0", nwe); end
        n_cmp++; if (pl_rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL rd_hold got %h want 1122334455667788", pl_rdata); end
    endtask

    task automatic test_range_err;
        int lat, nwe, ns;
        txn(0, 0, 64'h7F9, 64'h0, lat, nwe, ns);
        n_cmp++; if (lat !== 1 || ack_err !== 1'b1 || nwe !== 0) begin n_fail++; $display("FAIL err_7f9 got lat=%0d err=%b we=%0d want 1/1/0", lat, ack_err, nwe); end
        txn(0, 1, 64'h1_0000_0100, 64'hFFFF_FFFF_FFFF_FFFF, lat, nwe, ns);
        n_cmp++; if (lat !== 1 || ack_err !== 1'b1 || nwe !== 0) begin n_fail++; $display("FAIL err_high got lat=%0d err=%b we=%0d want 1/1/0", lat, ack_err, nwe); end
        n_cmp++; if (word_at(256) !== 64'h1122334455667788) begin n_fail++; $display("FAIL err_ram got %h want 1122334455667788", word_at(256)); end
    endtask

    task automatic test_reset_mid_write;
        int lat, nwe, ns, acks;
        logic hit;
        @(posedge clk); #1;
        pl_req = 1; pl_we = 1; pl_addr = 64'h100; pl_wdata = 64'hCAFEBABEDEADBEEF;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin @(negedge clk); hit = mem_we && mem_addr == 11'h103; end
        n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_reach_cnt3 got %b want 1", hit); end
        rst_n = 0; #1;
        n_cmp++; if ({mem_we, busy, pl_ack} !== 3'b0) begin n_fail++; $display("FAIL rst_async got we/busy/ack=%b want 000", {mem_we, busy, pl_ack}); end
        pl_req = 0;
        @(posedge clk); #1;
        rst_n = 1;
        acks = 0;
        repeat (12) begin @(negedge clk); if (pl_ack || ld_ack) acks++; end
        n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rst_no_ack got %0d want 0", acks); end
        n_cmp++; if (pl_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", pl_rdata); end
        n_cmp++; if (word_at(256) !== 64'h1122334455ADBEEF) begin n_fail++; $display("FAIL rst_ram got %h want 1122334455adbeef", word_at(256)); end
        txn(0, 0, 64'h100, 64'h0, lat, nwe, ns);
        n_cmp++; if (lat !== 9 || ack_rd !== 64'h1122334455ADBEEF) begin n_fail++; $display("FAIL rst_next got lat=%0d d=%h want 9/1122334455adbeef", lat, ack_rd); end
    endtask

    task automatic test_ld_last_word;
        int lat, nwe, ns;
        txn(1, 1, 64'h7F8, 64'hAAAA_AAAA_AAAA_AAAA, lat, nwe, ns);
        n_cmp++; if (lat !== 9 || ack_err !== 1'b0 || nwe !== 8) begin n_fail++; $display("FAIL ld_wr got lat=%0d err=%b we=%0d want 9/0/8", lat, ack_err, nwe); end
        n_cmp++; if (word_at(2040) !== 64'hAAAA_AAAA_AAAA_AAAA) begin n_fail++; $display("FAIL ld_ram got %h want aaaaaaaaaaaaaaaa", word_at(2040)); end
        n_cmp++; if (grant_ld !== 1'b1) begin n_fail++; $display("FAIL ld_grant got %b want 1", grant_ld); end
        txn(1, 0, 64'h7F8, 64'h0, lat, nwe, ns);
        n_cmp++; if (lat !== 9 || ld_rdata !== 64'hAAAA_AAAA_AAAA_AAAA) begin n_fail++; $display("FAIL ld_rd got lat=%0d d=%h want 9/aaaaaaaaaaaaaaaa", lat, ld_rdata); end
        n_cmp++; if (pl_rdata !== 64'h1122334455ADBEEF) begin n_fail++; $display("FAIL ld_pl_hold got %h want 1122334455adbeef", pl_rdata); end
    endtask

    task automatic test_simultaneous;
        int who;
        int exp_who [3];
`ifdef DMEM_ROUND_ROBIN_EN
        exp_who = '{0, 1, 0};
`else
        exp_who = '{0, 0, 0};
`endif
        @(posedge clk); #1; rst_n = 0;
        @(posedge clk); #1; rst_n = 1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            pl_req = 1; ld_req = 1; pl_we = 0; ld_we = 0; pl_addr = 64'h100; ld_addr = 64'h7F8;
            who = -1;
            for (int c = 0; c < 40 && who < 0; c++) begin
                @(negedge clk);
                if (pl_ack) who = 0; else if (ld_ack) who = 1;
            end
            @(posedge clk); #1; pl_req = 0; ld_req = 0;
            n_cmp++; if (who !== exp_who[r] || int'(grant_ld) !== exp_who[r]) begin n_fail++; $display("FAIL arb_round%0d got %0d/%b want %0d", r, who, grant_ld, exp_who[r]); end
        end
    endtask

    task automatic test_back_to_back;
        int first, second, t2, exp_first;
`ifdef DMEM_ROUND_ROBIN_EN
        exp_first = 1;
`else
        exp_first = 0;
`endif
        @(posedge clk); #1;
        pl_req = 1; ld_req = 1; pl_we = 0; ld_we = 0; pl_addr = 64'h100; ld_addr = 64'h7F8;
        first = -1; second = -1; t2 = -1;
        for (int c = 0; c < 60 && second < 0; c++) begin
            @(negedge clk);
            if (first < 0 && (pl_ack || ld_ack)) begin
                first = int'(ld_ack);
                @(posedge clk); #1;
                if (first == 1) ld_req = 0; else pl_req = 0;
            end else if (first >= 0 && (pl_ack || ld_ack)) begin
                second = int'(ld_ack); t2 = c;
            end
        end
        @(posedge clk); #1; pl_req = 0; ld_req = 0;
        n_cmp++; if (first !== exp_first || second !== 1 - exp_first) begin n_fail++; $display("FAIL b2b_order got %0d,%0d want %0d,%0d", first, second, exp_first, 1 - exp_first); end
        n_cmp++; if (t2 !== 19) begin n_fail++; $display("FAIL b2b_wait got %0d want 19", t2); end
    endtask

    initial begin
        test_reset;
        test_pl_write;
        test_pl_read;
        test_range_err;
        test_reset_mid_write;
        test_ld_last_word;
        test_simultaneous;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
